pickin_input: RTL and testbench
===============================

PICKIN_INPUT -- requirements
Module: pickin_input

Interface
REQ-001 Parameter COIN_PULSE_CYC, default 120000: coin pulse length and post-pulse guard length, in clk_sys cycles (10 ms at 12 MHz).
REQ-002 Parameter AUTOFIRE_DIV, default 600000: autofire half-period in clk_sys cycles.
REQ-003 clk_sys  in  1  system clock (12 MHz); the only clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ps2_key  in  11  [10] toggles once per key event, [9] is pressed, [8:0] is the scan code (bit 8 is extended).
REQ-006 joystick_0 / joystick_1  in  16 each  player 1 and player 2 pads: [0] right, [1] left, [2] down, [3] up, [4] fire, [5] start1, [6] start2, [7] coin.
REQ-007 rotate  in  1  1 means horizontal orientation, so directions are remapped.
REQ-008 autofire  in  2  per-player autofire request, [0] is P1 and [1] is P2.
REQ-009 p1_up/p1_down/p1_left/p1_right/p1_fire  out  1 each  player 1 controls.
REQ-010 p2_up/p2_down/p2_left/p2_right/p2_fire  out  1 each  player 2 controls.
REQ-011 start1, start2, test  out  1 each  level outputs.
REQ-012 coin1  out  1  shaped coin pulse.

Function
REQ-013 Key event SHALL be detected when ps2_key[10] differs from its registered previous value; exactly one event per toggle.
REQ-014 Arrow codes SHALL match on [7:0] only, ignoring bit 8: 0x75 up, 0x72 down, 0x6B left, 0x74 right.
REQ-015 All other codes SHALL match all 9 bits:
- P1: 0x029 and 0x014 fire; 0x005 and 0x016 start1; 0x006 and 0x01E start2.
- Coin: 0x02E coinA, 0x036 coinB.
- P2: 0x02D up, 0x02B down, 0x023 left, 0x034 right, 0x01C fire.
- 0x02C test.
REQ-016 On each event, the matched key register SHALL load ps2_key[9]; unmatched codes SHALL change nothing.
REQ-017 Each player's raw direction SHALL be the OR of that player's key register and its own joystick only (P1 uses joystick_0, P2 uses joystick_1).
REQ-018 When rotate=1, outputs SHALL be remapped from the raw signals: up takes left, down takes right, left takes down, right takes up; when rotate=0, straight through.
REQ-019 start1 and start2 SHALL each be the OR of the corresponding key and bits [5]/[6] of both joysticks.
REQ-020 All outputs SHALL be registered; a key event SHALL be visible on outputs exactly 2 clk_sys cycles after the ps2_key[10] toggle, and a joystick change exactly 1 cycle after.
REQ-021 Coin request SHALL be the rising edge of (coinA | coinB | joystick_0[7] | joystick_1[7]).
REQ-022 Coin FSM, three states:
- IDLE: on a request, go to PULSE.
- PULSE: coin1=1 for exactly COIN_PULSE_CYC cycles, then go to GUARD.
- GUARD: coin1=0 for COIN_PULSE_CYC cycles, then go to IDLE.
REQ-023 Requests arriving in PULSE or GUARD SHALL be dropped, not queued; simultaneous sources SHALL produce one pulse.
REQ-024 Coin counter SHALL be $clog2(COIN_PULSE_CYC+1) bits wide and SHALL not wrap; it clears on every state entry.

Reset
REQ-025 On reset, all key registers, all outputs and coin1 SHALL be 0, the coin FSM SHALL be IDLE, and the counters SHALL be 0.
REQ-026 During reset, the previous-toggle register SHALL load ps2_key[10], so releasing reset creates no spurious event.
REQ-027 Reset mid-pulse SHALL drop coin1 on the next cycle and abort the pulse with no resumption.
REQ-028 The coin-source edge detector SHALL load the current source level during reset, so a held coin does not fire after release.

Configuration
REQ-029 Macro INPUT_AUTOFIRE_EN: when defined, a player's fire output, while that player's fire is held and their autofire bit is 1, SHALL start at 1 and toggle every AUTOFIRE_DIV cycles.
REQ-030 The autofire phase counter SHALL restart on each fire press; a release SHALL force fire output to 0 on the next cycle.
REQ-031 When INPUT_AUTOFIRE_EN is undefined, the autofire port SHALL be ignored, fire output SHALL equal held fire, and no autofire counters SHALL be synthesized.

Structure
REQ-032 Package pickin_input_pkg SHALL hold the coin FSM state enum (IDLE/PULSE/GUARD), the scan-code localparams and the joystick bit-index localparams.
REQ-033 There SHALL be one sub-module, pickin_coin_shaper, which contains the coin FSM and its counter.

Verification
REQ-034 Reset, then ps2_key={~t,1,9'h175} -> p1_up=1 exactly 2 cycles later; with {t,0,9'h075} -> p1_up=0.
REQ-035 rotate=1, joystick_0=16'h0008 (up) -> p1_right=1 after 1 cycle, p1_up=0; joystick_1 unaffected, p2 outputs all 0.
REQ-036 COIN_PULSE_CYC=4; key 0x02E pressed, with joystick_1[7] rising 2 cycles later -> single coin1 high for exactly 4 cycles, then low for at least 4 cycles.
REQ-037 COIN_PULSE_CYC=4; reset asserted on pulse cycle 2 -> coin1=0 next cycle, no further pulse; coin still held after reset -> no pulse.
REQ-038 INPUT_AUTOFIRE_EN, AUTOFIRE_DIV=3, autofire=2'b01, P1 fire held 12 cycles -> p1_fire pattern 111000111000; with the macro undefined, the same stimulus -> p1_fire steady 1.
REQ-039 Unmapped code 0x0AA toggled while p1_fire=1 -> all outputs unchanged.

Source files
------------

// File: rtl/pickin_input_pkg.sv
// Shared definitions for the pickin_input keyboard/joystick front end:
// coin FSM states, PS/2 scan codes and joystick bit positions.
package pickin_input_pkg;

    typedef enum logic [1:0] {
        COIN_IDLE  = 2'd0,
        COIN_PULSE = 2'd1,
        COIN_GUARD = 2'd2
    } coin_state_t;

    // Arrow keys are matched on the low byte only (extended prefix ignored)
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [8:0] SC_P1_FIRE_A = 9'h029;
    localparam logic [8:0] SC_P1_FIRE_B = 9'h014;
    localparam logic [8:0] SC_START1_A  = 9'h005;
    localparam logic [8:0] SC_START1_B  = 9'h016;
    localparam logic [8:0] SC_START2_A  = 9'h006;
    localparam logic [8:0] SC_START2_B  = 9'h01E;
    localparam logic [8:0] SC_COIN_A    = 9'h02E;
    localparam logic [8:0] SC_COIN_B    = 9'h036;
    localparam logic [8:0] SC_P2_UP     = 9'h02D;
    localparam logic [8:0] SC_P2_DOWN   = 9'h02B;
    localparam logic [8:0] SC_P2_LEFT   = 9'h023;
    localparam logic [8:0] SC_P2_RIGHT  = 9'h034;
    localparam logic [8:0] SC_P2_FIRE   = 9'h01C;
    localparam logic [8:0] SC_TEST      = 9'h02C;

    localparam int unsigned JOY_RIGHT  = 0;
    localparam int unsigned JOY_LEFT   = 1;
    localparam int unsigned JOY_DOWN   = 2;
    localparam int unsigned JOY_UP     = 3;
    localparam int unsigned JOY_FIRE   = 4;
    localparam int unsigned JOY_START1 = 5;
    localparam int unsigned JOY_START2 = 6;
    localparam int unsigned JOY_COIN   = 7;

endpackage

// File: rtl/pickin_coin_shaper.sv
// Coin pulse shaper: one request yields a fixed-length high pulse followed by
// an equal-length low guard; requests outside IDLE are dropped.
module pickin_coin_shaper
    import pickin_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE_CYC = 120000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic i_req,
    output logic o_coin
);

    localparam int unsigned CW = $clog2(COIN_PULSE_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(COIN_PULSE_CYC - 1);

    coin_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic          r_coin;

    // The counter tops out at LAST because reaching it always leaves the state
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= COIN_IDLE;
            r_cnt   <= '0;
            r_coin  <= 1'b0;
        end else begin
            unique case (r_state)
                COIN_IDLE: begin
                    if (i_req) begin
                        r_state <= COIN_PULSE;
                        r_cnt   <= '0;
                        r_coin  <= 1'b1;
                    end
                end
                COIN_PULSE: begin
                    if (r_cnt == LAST) begin
                        r_state <= COIN_GUARD;
                        r_cnt   <= '0;
                        r_coin  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                COIN_GUARD: begin
                    if (r_cnt == LAST) begin
                        r_state <= COIN_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= COIN_IDLE;
                    r_cnt   <= '0;
                    r_coin  <= 1'b0;
                end
            endcase
        end
    end

    assign o_coin = r_coin;

endmodule

// File: rtl/pickin_input.sv
// PS/2 keyboard + two joystick input merger with rotation, coin shaping and
// optional per-player autofire (enabled by defining INPUT_AUTOFIRE_EN).
module pickin_input
    import pickin_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE_CYC = 120000,
    parameter int unsigned AUTOFIRE_DIV   = 600000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        rotate,
    input  logic [1:0]  autofire,
    output logic        p1_up,
    output logic        p1_down,
    output logic        p1_left,
    output logic        p1_right,
    output logic        p1_fire,
    output logic        p2_up,
    output logic        p2_down,
    output logic        p2_left,
    output logic        p2_right,
    output logic        p2_fire,
    output logic        start1,
    output logic        start2,
    output logic        test,
    output logic        coin1
);

    logic       r_tgl_d;
    logic       w_event;
    logic       w_press;
    logic [8:0] w_code;

    logic r_k1_up, r_k1_down, r_k1_left, r_k1_right, r_k1_fire;
    logic r_k2_up, r_k2_down, r_k2_left, r_k2_right, r_k2_fire;
    logic r_k_start1, r_k_start2, r_k_coin_a, r_k_coin_b, r_k_test;

    assign w_event = ps2_key[10] ^ r_tgl_d;
    assign w_press = ps2_key[9];
    assign w_code  = ps2_key[8:0];

    // Previous toggle tracks the input even in reset so release is event-free
    always_ff @(posedge clk_sys) begin
        r_tgl_d <= ps2_key[10];
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            {r_k1_up, r_k1_down, r_k1_left, r_k1_right, r_k1_fire}       <= '0;
            {r_k2_up, r_k2_down, r_k2_left, r_k2_right, r_k2_fire}       <= '0;
            {r_k_start1, r_k_start2, r_k_coin_a, r_k_coin_b, r_k_test}   <= '0;
        end else if (w_event) begin
            case (w_code[7:0])
                SC_UP:    r_k1_up    <= w_press;
                SC_DOWN:  r_k1_down  <= w_press;
                SC_LEFT:  r_k1_left  <= w_press;
                SC_RIGHT: r_k1_right <= w_press;
                default: begin
                    case (w_code)
                        SC_P1_FIRE_A, SC_P1_FIRE_B: r_k1_fire  <= w_press;
                        SC_START1_A,  SC_START1_B:  r_k_start1 <= w_press;
                        SC_START2_A,  SC_START2_B:  r_k_start2 <= w_press;
                        SC_COIN_A:                  r_k_coin_a <= w_press;
                        SC_COIN_B:                  r_k_coin_b <= w_press;
                        SC_P2_UP:                   r_k2_up    <= w_press;
                        SC_P2_DOWN:                 r_k2_down  <= w_press;
                        SC_P2_LEFT:                 r_k2_left  <= w_press;
                        SC_P2_RIGHT:                r_k2_right <= w_press;
                        SC_P2_FIRE:                 r_k2_fire  <= w_press;
                        SC_TEST:                    r_k_test   <= w_press;
                        default: ;
                    endcase
                end
            endcase
        end
    end

    logic w_p1_up, w_p1_down, w_p1_left, w_p1_right;
    logic w_p2_up, w_p2_down, w_p2_left, w_p2_right;
    logic [1:0] w_fire_held;
    logic [1:0] w_fire_out;

    assign w_p1_up    = r_k1_up    | joystick_0[JOY_UP];
    assign w_p1_down  = r_k1_down  | joystick_0[JOY_DOWN];
    assign w_p1_left  = r_k1_left  | joystick_0[JOY_LEFT];
    assign w_p1_right = r_k1_right | joystick_0[JOY_RIGHT];
    assign w_p2_up    = r_k2_up    | joystick_1[JOY_UP];
    assign w_p2_down  = r_k2_down  | joystick_1[JOY_DOWN];
    assign w_p2_left  = r_k2_left  | joystick_1[JOY_LEFT];
    assign w_p2_right = r_k2_right | joystick_1[JOY_RIGHT];

    assign w_fire_held[0] = r_k1_fire | joystick_0[JOY_FIRE];
    assign w_fire_held[1] = r_k2_fire | joystick_1[JOY_FIRE];

    logic w_unused;

`ifdef INPUT_AUTOFIRE_EN
    localparam int unsigned AW = $clog2(AUTOFIRE_DIV + 1);
    localparam logic [AW-1:0] AF_LAST = AW'(AUTOFIRE_DIV - 1);

    logic [AW-1:0] r_af_cnt   [2];
    logic [AW-1:0] w_af_cnt_n [2];
    logic [1:0]    r_af_phase;
    logic [1:0]    w_af_phase_n;
    logic [1:0]    r_held_d;

    // Output uses the next phase so a fresh press is high on its first cycle
    always_comb begin
        w_af_phase_n = '0;
        w_fire_out   = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            w_af_cnt_n[i] = '0;
            if (w_fire_held[i] && !r_held_d[i]) begin
                w_af_phase_n[i] = 1'b1;
            end else if (w_fire_held[i]) begin
                if (r_af_cnt[i] == AF_LAST) begin
                    w_af_phase_n[i] = ~r_af_phase[i];
                end else begin
                    w_af_phase_n[i] = r_af_phase[i];
                    w_af_cnt_n[i]   = r_af_cnt[i] + AW'(1);
                end
            end
            w_fire_out[i] = w_fire_held[i] & (autofire[i] ? w_af_phase_n[i] : 1'b1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_af_cnt[0] <= '0;
            r_af_cnt[1] <= '0;
            r_af_phase  <= '0;
            r_held_d    <= '0;
        end else begin
            r_af_cnt[0] <= w_af_cnt_n[0];
            r_af_cnt[1] <= w_af_cnt_n[1];
            r_af_phase  <= w_af_phase_n;
            r_held_d    <= w_fire_held;
        end
    end

    assign w_unused = &{joystick_0[15:8], joystick_1[15:8]};
`else
    assign w_fire_out = w_fire_held;
    assign w_unused   = &{joystick_0[15:8], joystick_1[15:8], autofire, (AUTOFIRE_DIV == 0)};
`endif

    logic r_p1_up, r_p1_down, r_p1_left, r_p1_right, r_p1_fire;
    logic r_p2_up, r_p2_down, r_p2_left, r_p2_right, r_p2_fire;
    logic r_start1, r_start2, r_test;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            {r_p1_up, r_p1_down, r_p1_left, r_p1_right, r_p1_fire} <= '0;
            {r_p2_up, r_p2_down, r_p2_left, r_p2_right, r_p2_fire} <= '0;
            {r_start1, r_start2, r_test}                           <= '0;
        end else begin
            if (rotate) begin
                r_p1_up    <= w_p1_left;
                r_p1_down  <= w_p1_right;
                r_p1_left  <= w_p1_down;
                r_p1_right <= w_p1_up;
                r_p2_up    <= w_p2_left;
                r_p2_down  <= w_p2_right;
                r_p2_left  <= w_p2_down;
                r_p2_right <= w_p2_up;
            end else begin
                r_p1_up    <= w_p1_up;
                r_p1_down  <= w_p1_down;
                r_p1_left  <= w_p1_left;
                r_p1_right <= w_p1_right;
                r_p2_up    <= w_p2_up;
                r_p2_down  <= w_p2_down;
                r_p2_left  <= w_p2_left;
                r_p2_right <= w_p2_right;
            end
            r_p1_fire <= w_fire_out[0];
            r_p2_fire <= w_fire_out[1];
            r_start1  <= r_k_start1 | joystick_0[JOY_START1] | joystick_1[JOY_START1];
            r_start2  <= r_k_start2 | joystick_0[JOY_START2] | joystick_1[JOY_START2];
            r_test    <= r_k_test;
        end
    end

    logic w_coin_src;
    logic r_coin_src_d;
    logic w_coin_req;

    assign w_coin_src = r_k_coin_a | r_k_coin_b | joystick_0[JOY_COIN] | joystick_1[JOY_COIN];
    assign w_coin_req = w_coin_src & ~r_coin_src_d;

    // Edge history follows the source during reset so a held coin stays quiet
    always_ff @(posedge clk_sys) begin
        r_coin_src_d <= w_coin_src;
    end

    pickin_coin_shaper #(
        .COIN_PULSE_CYC(COIN_PULSE_CYC)
    ) u_coin (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_req   (w_coin_req),
        .o_coin  (coin1)
    );

    assign p1_up    = r_p1_up;
    assign p1_down  = r_p1_down;
    assign p1_left  = r_p1_left;
    assign p1_right = r_p1_right;
    assign p1_fire  = r_p1_fire;
    assign p2_up    = r_p2_up;
    assign p2_down  = r_p2_down;
    assign p2_left  = r_p2_left;
    assign p2_right = r_p2_right;
    assign p2_fire  = r_p2_fire;
    assign start1   = r_start1;
    assign start2   = r_start2;
    assign test     = r_test;

endmodule

// File: tb/tb_pickin_input.sv
// Directed self-checking bench for pickin_input (COIN_PULSE_CYC=4, AUTOFIRE_DIV=3);
// autofire expectations follow INPUT_AUTOFIRE_EN.
module tb_pickin_input;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        rotate;
    logic [1:0]  autofire;
    logic p1_up, p1_down, p1_left, p1_right, p1_fire;
    logic p2_up, p2_down, p2_left, p2_right, p2_fire;
    logic start1, start2, test, coin1;

    logic [13:0] w_outs;
    assign w_outs = {p1_up, p1_down, p1_left, p1_right, p1_fire,
                     p2_up, p2_down, p2_left, p2_right, p2_fire,
                     start1, start2, test, coin1};

    int n_cmp  = 0;
    int n_fail = 0;
    logic r_tgl = 1'b0;

    always #5 clk_sys = ~clk_sys;

    pickin_input #(
        .COIN_PULSE_CYC(4),
        .AUTOFIRE_DIV  (3)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .rotate     (rotate),
        .autofire   (autofire),
        .p1_up      (p1_up),
        .p1_down    (p1_down),
        .p1_left    (p1_left),
        .p1_right   (p1_right),
        .p1_fire    (p1_fire),
        .p2_up      (p2_up),
        .p2_down    (p2_down),
        .p2_left    (p2_left),
        .p2_right   (p2_right),
        .p2_fire    (p2_fire),
        .start1     (start1),
        .start2     (start2),
        .test       (test),
        .coin1      (coin1)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_key(input logic pressed, input logic [8:0] code);
        r_tgl   = ~r_tgl;
        ps2_key = {r_tgl, pressed, code};
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [13:0] snap;
    logic [11:0] cap;
    logic        any_coin;

    initial begin
        // Reset with a pending toggle level and a pressed arrow on the bus
        reset      = 1'b1;
        ps2_key    = {1'b1, 1'b1, 9'h075};
        r_tgl      = 1'b1;
        joystick_0 = '0;
        joystick_1 = '0;
        rotate     = 1'b0;
        autofire   = 2'b00;
        ticks(3);
        check("reset_outs", 32'(w_outs), 32'h0);
        reset = 1'b0;
        ticks(3);
        check("no_spurious_event", 32'(w_outs), 32'h0);

        // Extended up arrow: two cycles of latency
        send_key(1'b1, 9'h175);
        tick();
        check("p1_up_lat1", 32'(p1_up), 32'h0);
        tick();
        check("p1_up_lat2", 32'(p1_up), 32'h1);
        send_key(1'b0, 9'h075);
        ticks(2);
        check("p1_up_release", 32'(p1_up), 32'h0);

        // Rotation with joystick up, then left
        rotate     = 1'b1;
        joystick_0 = 16'h0008;
        tick();
        check("rot_right", 32'(p1_right), 32'h1);
        check("rot_up", 32'(p1_up), 32'h0);
        check("rot_p2", 32'({p2_up, p2_down, p2_left, p2_right, p2_fire}), 32'h0);
        joystick_0 = 16'h0002;
        tick();
        check("rot_left_to_up", 32'(w_outs), 32'h2000);
        rotate     = 1'b0;
        joystick_0 = '0;
        tick();

        // P2 key and start/test sources
        send_key(1'b1, 9'h02D);
        ticks(2);
        check("p2_up_key", 32'(w_outs), 32'h0100);
        send_key(1'b0, 9'h02D);
        joystick_1 = 16'h0020;
        tick();
        check("start1_joy1", 32'({start1, start2}), 32'h2);
        joystick_1 = '0;
        send_key(1'b1, 9'h01E);
        ticks(2);
        check("start2_key", 32'(w_outs), 32'h0004);
        send_key(1'b0, 9'h01E);
        ticks(2);
        send_key(1'b1, 9'h02C);
        ticks(2);
        check("test_key", 32'(w_outs), 32'h0002);
        send_key(1'b0, 9'h02C);
        ticks(2);

        // Unmapped code while fire is held changes nothing
        send_key(1'b1, 9'h029);
        ticks(2);
        check("p1_fire_key", 32'(w_outs), 32'h0200);
        send_key(1'b1, 9'h0AA);
        ticks(3);
        check("unmapped_noop", 32'(w_outs), 32'h0200);
        send_key(1'b0, 9'h029);
        ticks(2);
        check("p1_fire_release", 32'(w_outs), 32'h0);

        // Coin key plus joystick_1 coin two cycles later: one 4-cycle pulse
        send_key(1'b1, 9'h02E);
        snap = '0;
        for (int i = 0; i < 14; i++) begin
            tick();
            snap[i] = coin1;
            if (i == 1) joystick_1 = 16'h0080;
        end
        check("coin_pulse_shape", 32'(snap), 32'h001E);
        send_key(1'b0, 9'h02E);
        joystick_1 = '0;
        ticks(12);

        // Reset on pulse cycle 2 aborts; held coin after release stays quiet
        joystick_0 = 16'h0080;
        tick();
        check("coin_mid_c1", 32'(coin1), 32'h1);
        tick();
        check("coin_mid_c2", 32'(coin1), 32'h1);
        reset = 1'b1;
        tick();
        check("coin_reset_drop", 32'(coin1), 32'h0);
        tick();
        reset    = 1'b0;
        any_coin = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            any_coin = any_coin | coin1;
        end
        check("coin_held_no_pulse", 32'(any_coin), 32'h0);
        joystick_0 = '0;
        ticks(2);

        // Autofire on P1 with joystick fire held 12 cycles
        autofire   = 2'b01;
        joystick_0 = 16'h0010;
        cap = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            cap[11 - i] = p1_fire;
        end
`ifdef INPUT_AUTOFIRE_EN
        check("autofire_pattern", 32'(cap), 32'hE38);
`else
        check("autofire_ignored", 32'(cap), 32'hFFF);
`endif
        joystick_0 = '0;
        tick();
        check("autofire_release", 32'(p1_fire), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
